hist_out_streamer: RTL and testbench
====================================

Name: hist_out_streamer

Overview:
- Downstream stage of the histogram-equalization top: after the top asserts done, reads the equalized image out of the output BRAM through its rd_addr/rd_data port.
- Emits the image as a valid/ready pixel stream, one byte per beat, in raster order, with start-of-frame, end-of-line and last markers.
- Replaces ad-hoc bench readback; feeds a future UART/display sink.
- Internal prefetch buffer hides the 1-cycle BRAM read latency, so full throughput (1 pixel/cycle) is sustained under arbitrary backpressure.

Parameters:
- W, 256, image width in pixels.
- H, 256, image height in pixels.
- TOTAL_PIXEL, W*H, pixels per frame.
- TOTAL_PIXEL_BIT, $clog2(W*H), address width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse (wired to top done); starts a frame readout.
- busy  output  1  high from the edge that accepts start until done.
- done  output  1  one-cycle pulse after the last beat is accepted.
- rd_addr  output  TOTAL_PIXEL_BIT  registered BRAM read address.
- rd_data  input  8  BRAM read data, valid one cycle after rd_addr is presented.
- m_valid  output  1  stream data valid.
- m_ready  input  1  sink ready; a beat transfers on an edge where m_valid && m_ready.
- m_data  output  8  pixel value.
- m_sof  output  1  high with pixel 0 of the frame.
- m_eol  output  1  high with the last pixel of each row (x == W-1).
- m_last  output  1  high with pixel TOTAL_PIXEL-1.

Behaviour:
- Reset: busy=0, done=0, rd_addr=0, m_valid=0, m_data=0, m_sof=0, m_eol=0, m_last=0; FSM IDLE; buffer empty; all counters 0.
- FSM states:
  - IDLE: start=1 -> RUN; rd_addr=0; read counter=0.
  - RUN: issues reads while addresses remain -> DRAIN once address TOTAL_PIXEL-1 has been issued.
  - DRAIN: waits for the buffer to empty and the last beat to be accepted -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
- Read issue: a read is issued on an edge only if (buffered entries + in-flight read) < 2. rd_addr increments by 1 per issued read and never exceeds TOTAL_PIXEL-1. rd_addr returns to 0 on entering IDLE.
- Capture: rd_data is captured exactly one cycle after its address was issued, into a 2-entry FIFO whose head drives m_data and the markers. Data is never dropped or duplicated.
- Latency: start sampled at edge E0 -> rd_addr=0 from E0 -> m_valid=1 after E2 with m_data=pixel 0, m_sof=1.
  - With m_ready held high, pixel k transfers at edge E(3+k).
  - done is high in the cycle after edge E(2+TOTAL_PIXEL).
  - Throughput is 1 beat/cycle.
- AXI-style rules:
  - m_valid never depends combinationally on m_ready.
  - Once m_valid=1, m_data/m_sof/m_eol/m_last hold stable until the beat is accepted.
  - m_valid is deasserted only after an accepted beat with an empty buffer.
- Markers come from x/y counters (x in 0..W-1, y in 0..H-1) that advance on each accepted beat:
  - m_sof = (x==0 && y==0).
  - m_eol = (x==W-1).
  - m_last = (x==W-1 && y==H-1).
- Backpressure: while m_ready=0, at most 2 pixels are buffered and rd_addr stalls. When m_ready rises, the stream resumes with no bubble.
- start while busy=1 (including in the DONE cycle) is ignored.
- W=1 or H=1 are legal: W=1 asserts m_eol on every beat; TOTAL_PIXEL=1 asserts m_sof, m_eol and m_last on the same beat.
- rst_n low mid-frame: all state returns to reset values immediately; the partial frame is discarded. The next start restarts at address 0.

Test Plan:
- W=4,H=3, BRAM preloaded with addr^8'h5A, start pulse, m_ready=1 -> 12 beats at consecutive edges E3..E14 with data 5A,5B,58,59,...; m_sof on beat 0; m_eol on beats 3,7,11; m_last on beat 11; done one cycle after E14; busy low thereafter.
- Same image, m_ready toggled with pseudo-random 50% duty -> identical 12-byte sequence, no drop or duplicate, outputs stable while stalled, rd_addr never more than 2 ahead of the accepted count.
- m_ready=0 for 20 cycles after start -> m_valid=1 with data 5A held; rd_addr stops at 2; releasing m_ready gives back-to-back beats 5A,5B,58 with no bubble.
- start pulsed again at beat 5 and in the DONE cycle -> ignored; exactly 12 beats, one done pulse.
- rst_n asserted at beat 6, released, start -> outputs zero during reset; new frame begins at pixel 0 with m_sof and delivers all 12 beats.
- W=1,H=1 -> single beat with m_sof=m_eol=m_last=1; done follows.

Source files
------------

// File: rtl/hist_out_streamer.sv
// Purpose:      reads the equalized frame out of the output BRAM and emits it as a raster-order byte stream.
// Latency:      start sampled at E0 -> first beat valid after E2; with m_ready high, pixel k transfers at E(3+k).
// Backpressure: 2-entry prefetch buffer; reads stall when it would overflow; 1 beat/cycle under any m_ready pattern.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, busy, done  frame trigger (ignored unless idle), in-progress flag, end-of-frame pulse
//   rd_addr, rd_data   BRAM read port (data valid one cycle after address)
//   m_valid, m_ready   stream handshake
//   m_data             pixel byte
//   m_sof, m_eol, m_last  start of frame, end of row, last pixel of frame
module hist_out_streamer #(
  parameter int W               = 256,
  parameter int H               = 256,
  parameter int TOTAL_PIXEL     = W * H,
  parameter int TOTAL_PIXEL_BIT = (TOTAL_PIXEL > 1) ? $clog2(TOTAL_PIXEL) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [TOTAL_PIXEL_BIT-1:0] rd_addr,
  input  logic [7:0]                 rd_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [7:0]                 m_data,
  output logic                       m_sof,
  output logic                       m_eol,
  output logic                       m_last
);

  localparam int XW = (W > 1) ? $clog2(W) : 1;
  localparam int YW = (H > 1) ? $clog2(H) : 1;
  localparam logic [TOTAL_PIXEL_BIT-1:0] LAST_ADDR = TOTAL_PIXEL_BIT'(TOTAL_PIXEL - 1);
  localparam logic [XW-1:0] X_MAX = XW'(W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(H - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [7:0]    buf_mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    buf_cnt;
  logic          inflight;   // a read was issued last edge; its data is on rd_data now
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;

  logic       pop;
  logic       issue;
  logic       last_addr;
  logic [2:0] occ_after;

  assign pop       = (buf_cnt != 2'd0) && m_ready;
  assign last_addr = (rd_addr == LAST_ADDR);

  // Occupancy counts the beat leaving on this edge, so a full-rate stream
  // keeps one entry buffered plus one read in flight without a bubble.
  assign occ_after = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == S_RUN) && (occ_after < 3'd2);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (issue && last_addr) state_nxt = S_DRAIN;
      // Last beat leaving with nothing behind it in the buffer or in flight.
      S_DRAIN: if (pop && (buf_cnt == 2'd1) && !inflight) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_RUN, S_DRAIN: busy = 1'b1;
      S_DONE:         done = 1'b1;
      default: ;
    endcase
  end

  // Read issue, prefetch buffer and raster position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr    <= '0;
      inflight   <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      buf_cnt    <= 2'd0;
      buf_mem[0] <= 8'h00;
      buf_mem[1] <= 8'h00;
      x_cnt      <= '0;
      y_cnt      <= '0;
    end else begin
      // Address holds at the last pixel during drain and rewinds on the way back to idle.
      if (state == S_DONE) begin
        rd_addr <= '0;
      end else if (issue && !last_addr) begin
        rd_addr <= rd_addr + TOTAL_PIXEL_BIT'(1);
      end

      inflight <= issue;

      if (inflight) begin
        buf_mem[wr_ptr] <= rd_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      case ({inflight, pop})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase

      // x/y describe the head beat; both wrap to 0 after the last pixel.
      if (pop) begin
        if (x_cnt == X_MAX) begin
          x_cnt <= '0;
          y_cnt <= (y_cnt == Y_MAX) ? '0 : y_cnt + YW'(1);
        end else begin
          x_cnt <= x_cnt + XW'(1);
        end
      end
    end
  end

  assign m_valid = (buf_cnt != 2'd0);
  assign m_data  = m_valid ? buf_mem[rd_ptr] : 8'h00;
  assign m_sof   = m_valid && (x_cnt == '0) && (y_cnt == '0);
  assign m_eol   = m_valid && (x_cnt == X_MAX);
  assign m_last  = m_valid && (x_cnt == X_MAX) && (y_cnt == Y_MAX);

endmodule

// File: tb/tb_hist_out_streamer.sv
module tb_hist_out_streamer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int AW = $clog2(N);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start, busy, done;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          m_valid, m_ready, m_sof, m_eol, m_last;
  logic [7:0]    m_data;

  logic       s_start, s_busy, s_done;
  logic [0:0] s_addr;
  logic [7:0] s_rdata, s_data;
  logic       s_valid, s_ready, s_sof, s_eol, s_last;

  hist_out_streamer #(.W(W), .H(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .m_last(m_last)
  );

  hist_out_streamer #(.W(1), .H(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done),
    .rd_addr(s_addr), .rd_data(s_rdata),
    .m_valid(s_valid), .m_ready(s_ready), .m_data(s_data),
    .m_sof(s_sof), .m_eol(s_eol), .m_last(s_last)
  );

  // BRAM models: one-cycle registered read
  logic [7:0] mem [N];
  always @(posedge clk) rd_data <= mem[rd_addr];
  always @(posedge clk) s_rdata <= (s_addr == 1'b0) ? 8'hC3 : 8'hEE;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: beat k of the frame carries k^5A, sof at k==0, eol at
  // k%W==W-1, last at k==N-1. Pixel k must transfer at edge E0+3+k when
  // timing is being checked (m_ready held high).
  int          beat_idx  = 0;
  int          dones     = 0;
  bit          timing_on = 1'b0;
  int          e0        = 0;
  logic [7:0]  got_data [N];
  logic [N-1:0] got_sof, got_eol, got_last;
  bit          p_hold = 1'b0;
  logic [10:0] p_out;

  always @(negedge clk) begin
    if (!rst_n) begin
      beat_idx = 0;
      p_hold   = 1'b0;
    end else begin
      if (p_hold) begin
        chk("hold_valid", m_valid, 1'b1);
        chk("hold_payload", {m_data, m_sof, m_eol, m_last}, p_out);
      end
      chk("addr_lead", (int'(rd_addr) <= beat_idx + 2), 1'b1);
      if (m_valid) begin
        chk("busy_with_valid", busy, 1'b1);
        if (beat_idx < N) begin
          chk("beat_payload", {m_data, m_sof, m_eol, m_last},
              {8'(beat_idx) ^ 8'h5A, beat_idx == 0, (beat_idx % W) == W - 1, beat_idx == N - 1});
          if (m_ready) begin
            got_data[beat_idx] = m_data;
            got_sof[beat_idx]  = m_sof;
            got_eol[beat_idx]  = m_eol;
            got_last[beat_idx] = m_last;
            if (timing_on) chk("beat_edge", edges + 1, e0 + 3 + beat_idx);
            beat_idx++;
          end
        end else begin
          chk("valid_after_frame", m_valid, 1'b0);
        end
      end
      if (done) begin
        chk("done_after_all", beat_idx, N);
        chk("busy_in_done", busy, 1'b0);
        if (timing_on) chk("done_edge", edges, e0 + 2 + N);
        dones++;
        beat_idx = 0;
      end
      p_hold = m_valid && !m_ready;
      p_out  = {m_data, m_sof, m_eol, m_last};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    e0    = edges;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk({name, "_done_seen"}, seen, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int nb;
    int dn;
    int e1;
    bit seen;

    for (int i = 0; i < N; i++) mem[i] = 8'(i) ^ 8'h5A;
    rst_n = 1'b0; start = 1'b0; m_ready = 1'b0;
    s_start = 1'b0; s_ready = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_state", {busy, done, rd_addr, m_valid, m_data, m_sof, m_eol, m_last}, '0);
    chk("rst_state_w1", {s_busy, s_done, s_addr, s_valid, s_data, s_sof, s_eol, s_last}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(); tick();

    // 1: full rate, exact timing, literal image content
    m_ready   = 1'b1;
    timing_on = 1'b1;
    pulse_start();
    chk("busy_after_start", busy, 1'b1);
    wait_done("t1", 60);
    tick();
    timing_on = 1'b0;
    chk("t1_done_one_cycle", done, 1'b0);
    chk("t1_idle", {busy, rd_addr, m_valid}, '0);
    chk("lit_b0", got_data[0], 8'h5A);
    chk("lit_b1", got_data[1], 8'h5B);
    chk("lit_b2", got_data[2], 8'h58);
    chk("lit_b11", got_data[11], 8'h51);
    chk("lit_sof_mask", got_sof, 12'h001);
    chk("lit_eol_mask", got_eol, 12'h888);
    chk("lit_last_mask", got_last, 12'h800);

    // 2: random backpressure
    d0 = dones;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      m_ready = 1'($urandom % 2);
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t2_done_seen", seen, 1'b1);
    m_ready = 1'b1;
    tick();
    chk("t2_one_done", dones - d0, 1);

    // 3: sink stalled for 20 cycles, then released
    m_ready = 1'b0;
    pulse_start();
    repeat (20) tick();
    chk("t3_stall_valid", m_valid, 1'b1);
    chk("t3_stall_data", m_data, 8'h5A);
    chk("t3_stall_addr", rd_addr, 4'd2);
    m_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      chk("t3_no_bubble", m_valid, 1'b1);
      tick();
    end
    wait_done("t3", 5);
    tick();

    // 4: start pulses mid-frame and in the done cycle are ignored
    d0 = dones;
    pulse_start();
    for (int i = 0; i < 50 && beat_idx < 5; i++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t4", 60);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("t4_idle_after", {busy, m_valid, rd_addr}, '0);
    chk("t4_one_done", dones - d0, 1);

    // 5: reset in the middle of a frame
    pulse_start();
    for (int i = 0; i < 50 && beat_idx < 6; i++) tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_outputs", {busy, done, rd_addr, m_valid, m_data, m_sof, m_eol, m_last}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(); tick();
    d0        = dones;
    timing_on = 1'b1;
    pulse_start();
    wait_done("t5", 60);
    tick();
    timing_on = 1'b0;
    chk("t5_one_done", dones - d0, 1);
    chk("t5_sof_first", got_sof, 12'h001);

    // 6: 1x1 image
    s_ready = 1'b1;
    s_start = 1'b1;
    tick();
    e1      = edges;
    s_start = 1'b0;
    nb = 0;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (s_valid && s_ready) begin
        chk("w1_beat", {s_data, s_sof, s_eol, s_last}, {8'hC3, 3'b111});
        chk("w1_beat_edge", edges + 1, e1 + 3);
        nb++;
      end
      if (s_done) begin
        chk("w1_done_edge", edges, e1 + 3);
        dn++;
      end
    end
    chk("w1_beats", nb, 1);
    chk("w1_dones", dn, 1);
    chk("w1_idle", {s_busy, s_valid, s_addr}, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
